// File: rtl/mic_spi_pkg.sv
// Shared types and defaults for the microphone SPI sampler.
package mic_spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_LO = 3'd2,
    SCLK_HI = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam int CLK_DIV_DEF       = 4;
  localparam int FRAME_BITS_DEF    = 16;
  localparam int DATA_BITS_DEF     = 12;
  localparam int SAMPLE_PERIOD_DEF = 15625;

  // PCLK cycles with CS_b low for one frame: setup, 2*bits half-periods, hold.
  function automatic int frame_cycles(input int div, input int bits);
    return div * (2 * bits + 2);
  endfunction

endpackage

// File: rtl/mic_spi_sclk_gen.sv
// CS_b/sclk sequencer: half-period counter, frame FSM and bit counter.
module mic_spi_sclk_gen
  import mic_spi_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic   PCLK,
  input  logic   PRESET,
  input  logic   start,
  input  logic   abort,
  output logic   CS_b,
  output logic   sclk,
  output logic   sample_strobe,
  output logic   frame_done,
  output state_t fsm_state
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS + 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            cs_b_d, sclk_d;
  logic            last;

  assign last          = (div_q == DW'(CLK_DIV - 1));
  assign fsm_state     = state_q;
  assign sample_strobe = (state_q == SCLK_LO) && last && !abort;
  assign frame_done    = (state_q == HOLD) && last && !abort;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      CS_b    <= 1'b1;
      sclk    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      CS_b    <= cs_b_d;
      sclk    <= sclk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cs_b_d  = CS_b;
    sclk_d  = sclk;
    bit_d   = bit_q;
    div_d   = (state_q == IDLE || last) ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        cs_b_d  = 1'b0;
        sclk_d  = 1'b1;
        bit_d   = '0;
      end
      SETUP: if (last) begin
        state_d = SCLK_LO;
        sclk_d  = 1'b0;
      end
      SCLK_LO: if (last) begin
        state_d = SCLK_HI;
        sclk_d  = 1'b1;
        bit_d   = bit_q + 1'b1;
      end
      SCLK_HI: if (last) begin
        if (bit_q < BW'(FRAME_BITS)) begin
          state_d = SCLK_LO;
          sclk_d  = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: if (last) begin
        state_d = IDLE;
        cs_b_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Disable drops the frame immediately and parks the bus idle.
    if (abort) begin
      state_d = IDLE;
      cs_b_d  = 1'b1;
      sclk_d  = 1'b1;
      div_d   = '0;
    end
  end

endmodule

// File: rtl/mic_spi_sampler.sv
// Microphone ADC SPI front-end: periodic frame, 12-bit capture, valid/ready out.
module mic_spi_sampler
  import mic_spi_pkg::*;
#(
  parameter int CLK_DIV       = CLK_DIV_DEF,
  parameter int FRAME_BITS    = FRAME_BITS_DEF,
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 enable,
  input  logic                 MISO,
  output logic                 CS_b,
  output logic                 sclk,
  output logic [DATA_BITS-1:0] sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  output logic [7:0]           overrun_count,
  output logic                 busy
);

  localparam int TW = $clog2(SAMPLE_PERIOD + 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("mic_spi_sampler: CLK_DIV must be at least 2");
  end
  if (DATA_BITS > FRAME_BITS || FRAME_BITS < 2) begin : g_bad_bits
    $error("mic_spi_sampler: need 2 <= FRAME_BITS and DATA_BITS <= FRAME_BITS");
  end
  if (SAMPLE_PERIOD < frame_cycles(CLK_DIV, FRAME_BITS) + 2) begin : g_bad_period
    $error("mic_spi_sampler: SAMPLE_PERIOD shorter than one frame plus gap");
  end

  logic [TW-1:0]         timer_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  start, sample_strobe, frame_done;
  state_t                fsm_state;

  assign start = enable && (timer_q == '0) && (fsm_state == IDLE);
  assign busy  = ~CS_b;

  mic_spi_sclk_gen #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_sclk_gen (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .start         (start),
    .abort         (~enable),
    .CS_b          (CS_b),
    .sclk          (sclk),
    .sample_strobe (sample_strobe),
    .frame_done    (frame_done),
    .fsm_state     (fsm_state)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      timer_q <= '0;
      shift_q <= '0;
    end else begin
      if (!enable)               timer_q <= '0;
      else if (start)            timer_q <= TW'(SAMPLE_PERIOD - 1);
      else if (timer_q != '0)    timer_q <= timer_q - 1'b1;
      if (sample_strobe) shift_q <= {shift_q[FRAME_BITS-2:0], MISO};
    end
  end

  // Handshake: a sample transfers on any cycle with sample_valid && sample_ready;
  // sample_data never changes while sample_valid is high unless that same cycle
  // transfers, and a frame finishing against a stalled consumer is dropped.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sample_data   <= '0;
      sample_valid  <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!sample_valid || sample_ready) begin
          sample_data  <= shift_q[DATA_BITS-1:0];
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
          if (overrun_count != 8'hFF) overrun_count <= overrun_count + 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mic_spi_sampler.sv
// Directed bench for mic_spi_sampler with a short sample period to keep runs brief.
module tb_mic_spi_sampler;

  localparam int CLK_DIV       = 4;
  localparam int FRAME_BITS    = 16;
  localparam int DATA_BITS     = 12;
  localparam int SAMPLE_PERIOD = 200;

  logic                 PCLK;
  logic                 PRESET;
  logic                 enable;
  logic                 MISO;
  logic                 CS_b;
  logic                 sclk;
  logic [DATA_BITS-1:0] sample_data;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 overrun;
  logic [7:0]           overrun_count;
  logic                 busy;

  int vectors     = 0;
  int miscompares = 0;

  mic_spi_sampler #(
    .CLK_DIV       (CLK_DIV),
    .FRAME_BITS    (FRAME_BITS),
    .DATA_BITS     (DATA_BITS),
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .enable        (enable),
    .MISO          (MISO),
    .CS_b          (CS_b),
    .sclk          (sclk),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun),
    .overrun_count (overrun_count),
    .busy          (busy)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ADC model: presents tx_word MSB first, advancing on sclk falling edges
  logic [15:0] tx_word;
  int          nfall;
  int          miso_idx;
  initial nfall = 0;
  always @(negedge sclk or negedge CS_b) begin
    if (sclk)       nfall = 0;
    else if (!CS_b) nfall = nfall + 1;
  end
  always_comb begin
    if (nfall <= 1)       miso_idx = 15;
    else if (nfall >= 16) miso_idx = 0;
    else                  miso_idx = 16 - nfall;
    MISO = tx_word[miso_idx];
  end

  // free-running monitors (read as differences from snapshots)
  int cyc = 0, low_cnt = 0, vcnt = 0, ocnt = 0, rise_cnt = 0;
  int last_fall = 0, prev_fall = 0;
  always @(posedge PCLK) begin
    cyc = cyc + 1;
    if (!CS_b)        low_cnt = low_cnt + 1;
    if (sample_valid) vcnt = vcnt + 1;
    if (overrun)      ocnt = ocnt + 1;
  end
  always @(posedge sclk) if (!CS_b) rise_cnt = rise_cnt + 1;
  always @(negedge CS_b) begin
    prev_fall = last_fall;
    last_fall = cyc;
  end

  // driver / checker tasks
  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cs(input logic lvl, input int budget, input string tag);
    int i = 0;
    while (CS_b !== lvl && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, 32'(CS_b === lvl), 32'd1);
  endtask

  int l0, r0, v0, o0;

  initial begin
    PRESET       = 1'b1;
    enable       = 1'b0;
    sample_ready = 1'b1;
    tx_word      = 16'hFFFF;
    tick(3);
    chk("rst_cs_b",  32'(CS_b), 32'd1);
    chk("rst_sclk",  32'(sclk), 32'd1);
    chk("rst_data",  32'(sample_data), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_ovr",   32'(overrun), 32'd0);
    chk("rst_count", 32'(overrun_count), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);

    // first frame, constant ones, always ready
    PRESET = 1'b0;
    tick(2);
    chk("idle_cs_b", 32'(CS_b), 32'd1);
    enable = 1'b1;
    tick(1);
    chk("first_fall", 32'(CS_b), 32'd0);
    chk("first_busy", 32'(busy), 32'd1);
    l0 = low_cnt;
    r0 = rise_cnt;
    wait_cs(1'b1, 200, "f1_end");
    chk("f1_low_cycles", 32'(low_cnt - l0), 32'd136);
    chk("f1_sclk_rises", 32'(rise_cnt - r0), 32'd16);
    chk("f1_valid", 32'(sample_valid), 32'd1);
    chk("f1_data",  32'(sample_data), 32'hFFF);
    tick(1);
    chk("f1_valid_drop", 32'(sample_valid), 32'd0);

    // serialized word
    tx_word = 16'h0A5C;
    wait_cs(1'b0, 250, "f2_start");
    chk("f2_spacing", 32'(last_fall - prev_fall), 32'd200);
    wait_cs(1'b1, 200, "f2_end");
    chk("f2_valid", 32'(sample_valid), 32'd1);
    chk("f2_data",  32'(sample_data), 32'hA5C);
    tick(1);
    chk("f2_valid_drop", 32'(sample_valid), 32'd0);

    // overrun: consumer stalls over three frames
    sample_ready = 1'b0;
    tx_word      = 16'h1234;
    wait_cs(1'b0, 250, "f3_start");
    chk("f3_spacing", 32'(last_fall - prev_fall), 32'd200);
    wait_cs(1'b1, 200, "f3_end");
    chk("f3_valid", 32'(sample_valid), 32'd1);
    chk("f3_data",  32'(sample_data), 32'h234);
    chk("f3_ovr",   32'(overrun), 32'd0);
    tx_word = 16'hF0F0;
    o0 = ocnt;
    wait_cs(1'b0, 250, "f4_start");
    wait_cs(1'b1, 200, "f4_end");
    chk("f4_ovr",   32'(overrun), 32'd1);
    chk("f4_count", 32'(overrun_count), 32'd1);
    chk("f4_data",  32'(sample_data), 32'h234);
    tick(1);
    chk("f4_ovr_pulse", 32'(overrun), 32'd0);
    wait_cs(1'b0, 250, "f5_start");
    wait_cs(1'b1, 200, "f5_end");
    tick(1);
    chk("f5_count",  32'(overrun_count), 32'd2);
    chk("f5_pulses", 32'(ocnt - o0), 32'd2);
    chk("f5_data",   32'(sample_data), 32'h234);
    chk("f5_valid",  32'(sample_valid), 32'd1);

    // consumer returns
    sample_ready = 1'b1;
    tx_word      = 16'h0ABC;
    tick(1);
    chk("ret_valid_drop", 32'(sample_valid), 32'd0);
    wait_cs(1'b0, 250, "f6_start");
    wait_cs(1'b1, 200, "f6_end");
    chk("f6_valid", 32'(sample_valid), 32'd1);
    chk("f6_data",  32'(sample_data), 32'hABC);
    tick(1);

    // disable at bit 7, then re-enable
    tx_word = 16'h0777;
    wait_cs(1'b0, 250, "f7_start");
    r0 = rise_cnt;
    for (int i = 0; i < 100 && (rise_cnt - r0) < 7; i++) tick(1);
    chk("f7_bit7", 32'(rise_cnt - r0), 32'd7);
    enable = 1'b0;
    tick(1);
    chk("dis_cs_b", 32'(CS_b), 32'd1);
    chk("dis_sclk", 32'(sclk), 32'd1);
    chk("dis_busy", 32'(busy), 32'd0);
    v0 = vcnt;
    o0 = ocnt;
    tick(250);
    chk("dis_no_valid",  32'(vcnt - v0), 32'd0);
    chk("dis_no_ovr",    32'(ocnt - o0), 32'd0);
    chk("dis_count",     32'(overrun_count), 32'd2);
    chk("dis_cs_idle",   32'(CS_b), 32'd1);
    enable = 1'b1;
    tick(1);
    chk("reen_fall", 32'(CS_b), 32'd0);
    wait_cs(1'b1, 200, "f8_end");
    chk("f8_valid", 32'(sample_valid), 32'd1);
    chk("f8_data",  32'(sample_data), 32'h777);

    // saturation: 300 dropped frames
    sample_ready = 1'b0;
    tx_word      = 16'h0123;
    for (int k = 0; k < 300; k++) begin
      wait_cs(1'b0, 250, "sat_start");
      wait_cs(1'b1, 200, "sat_end");
    end
    tick(1);
    chk("sat_count", 32'(overrun_count), 32'd255);
    chk("sat_data",  32'(sample_data), 32'h777);
    chk("sat_valid", 32'(sample_valid), 32'd1);

    // asynchronous reset during SCLK_LO
    wait_cs(1'b0, 250, "rf_start");
    for (int i = 0; i < 20 && sclk !== 1'b0; i++) tick(1);
    chk("rf_in_lo", 32'(sclk), 32'd0);
    PRESET = 1'b1;
    #1;
    chk("rf_cs_b",  32'(CS_b), 32'd1);
    chk("rf_sclk",  32'(sclk), 32'd1);
    chk("rf_valid", 32'(sample_valid), 32'd0);
    chk("rf_count", 32'(overrun_count), 32'd0);
    chk("rf_data",  32'(sample_data), 32'h0);
    enable = 1'b0;
    tick(2);
    PRESET = 1'b0;
    tick(2);
    chk("rf_idle", 32'(CS_b), 32'd1);
    enable = 1'b1;
    tick(1);
    chk("rf_first_fall", 32'(CS_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mic_spi_sampler.md
Name: mic_spi_sampler

Overview:
- SPI master front-end for the microphone ADC, directly upstream of the APB sample buffer.
- Periodically runs one SPI frame (CS_b/sclk/MISO), deserializes it MSB-first and extracts a 12-bit sample.
- Hands each sample downstream over a valid/ready handshake.
- Flags samples dropped because the consumer stalled.

Parameters:
- CLK_DIV, 4, PCLK cycles per sclk half-period (≥2).
- FRAME_BITS, 16, sclk cycles per frame.
- DATA_BITS, 12, sample width; the LSBs of the frame (≤FRAME_BITS).
- SAMPLE_PERIOD, 15625, PCLK cycles between frame starts (8 kHz at 125 MHz). Elaboration error if < CLK_DIV*(2*FRAME_BITS+2)+2.

Ports:
- PCLK  in  1  system clock, 125 MHz.
- PRESET  in  1  asynchronous active-high reset.
- enable  in  1  sampling enable.
- MISO  in  1  ADC serial data.
- CS_b  out  1  ADC chip select, active low.
- sclk  out  1  SPI clock; idles high.
- sample_data  out  DATA_BITS  captured sample.
- sample_valid  out  1  sample_data valid.
- sample_ready  in  1  consumer accepts.
- overrun  out  1  one-cycle pulse on a dropped sample.
- overrun_count  out  8  saturating dropped-sample count.
- busy  out  1  frame in progress (CS_b low).

Behaviour:
- Single clock: PCLK. Reset is asynchronous and active-high (PRESET).
- Reset values: CS_b=1, sclk=1, sample_data=0, sample_valid=0, overrun=0, overrun_count=0, busy=0, FSM=IDLE, timer=0, shift register=0.
- Timer:
  - Counts down from SAMPLE_PERIOD-1 to 0 while enable=1.
  - Held at 0 while enable=0.
  - At 0 with FSM IDLE and enable=1: start frame, reload SAMPLE_PERIOD-1.
  - First frame: CS_b falls 1 cycle after enable is first sampled high.
- FSM states IDLE, SETUP, SCLK_LO, SCLK_HI, HOLD. Each non-IDLE state lasts CLK_DIV cycles.
  - IDLE→SETUP: CS_b=0, sclk=1.
  - SETUP→SCLK_LO: sclk=0.
  - SCLK_LO→SCLK_HI: sclk=1. MISO shifted into the LSB of the shift register on this transition cycle.
  - SCLK_HI→SCLK_LO while bit count < FRAME_BITS, otherwise →HOLD.
  - HOLD→IDLE: CS_b=1.
- Frame length: CLK_DIV*(2*FRAME_BITS+2) cycles with CS_b low (136 at defaults).
- busy equals ~CS_b.
- Completion, on the HOLD→IDLE cycle:
  - If sample_valid=0, or (sample_valid=1 and sample_ready=1) on that same cycle: sample_data ← shift[DATA_BITS-1:0], sample_valid=1 next cycle.
  - Else the new sample is dropped and sample_data is kept unchanged; overrun pulses 1 cycle; overrun_count increments, saturating at 255.
- Handshake:
  - Transfer happens when sample_valid & sample_ready.
  - sample_valid clears the next cycle unless a new sample loads on the same cycle.
  - sample_data is stable while valid=1.
- Disable mid-frame:
  - Next cycle: CS_b=1, sclk=1, FSM=IDLE. No sample, no overrun.
  - sample_valid and any pending sample are unaffected.
- Re-enable: the timer restarts from 0, so the first frame starts 1 cycle after enable is sampled high.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); the frame is lost.
- sclk and CS_b are registered outputs with no combinational path from inputs.

Decomposition:
- Package mic_spi_pkg:
  - state_t enum (IDLE, SETUP, SCLK_LO, SCLK_HI, HOLD).
  - Default constants: CLK_DIV, FRAME_BITS, DATA_BITS, SAMPLE_PERIOD.
  - Function frame_cycles(div, bits).
- Sub-module mic_spi_sclk_gen:
  - Half-period counter plus the CS_b/sclk FSM and bit counter.
  - Outputs a sample_strobe and a frame_done pulse.
- The top holds the sample timer, shift register, output register and overrun logic.

Test Plan:
- Reset mid-frame: assert PRESET during SCLK_LO → CS_b=1, sclk=1, sample_valid=0 in the same cycle; after release, the first CS_b fall occurs 1 cycle after enable.
- Constant pattern, downstream always ready: MISO=1, enable=1, sample_ready=1 →
  - CS_b low for exactly 136 cycles with 16 sclk rising edges.
  - sample_data=0xFFF, sample_valid high for 1 cycle.
  - Frame starts 15625 cycles apart.
- Serialized word: MISO driven with 16'h0A5C, MSB first, changed on sclk falling edges → sample_data=12'hA5C.
- Overrun: sample_ready=0 for 3 frames → first sample held; 2 overrun pulses; overrun_count=2; sample_data still holds the first sample.
- Consumer returns: raise sample_ready → valid drops 1 cycle later; the next frame loads normally.
- Disable mid-frame: enable=0 at bit 7 → CS_b=1 next cycle, no new sample_valid, no overrun; re-enable → next CS_b fall 1 cycle later.
- Counter saturation: sample_ready=0 for 300 frames → overrun_count=255.
